// File: rtl/hazard_pkg.sv
// Shared types and limits for the hazard scoreboard (scoreboard entry, forward-select encoding).
package hazard_pkg;

  localparam int unsigned RD_MAX_W  = 8;
  localparam int unsigned DEPTH_MIN = 2;
  localparam int unsigned DEPTH_MAX = 6;
  localparam int unsigned FWD_RF    = 0;

  // rd is stored at the widest supported width so the struct needs no parameter
  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                we;
    logic                is_load;
  } sb_entry_t;

  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one source register against every scoreboard entry; reports hits,
// the youngest hit as a forward select (index+1, 0 = register file) and a load-use hit.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned FSEL_W = $clog2(DEPTH + 1)
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_used,
  input  sb_entry_t         entries [DEPTH],
  output logic [DEPTH-1:0]  hit,
  output logic [FSEL_W-1:0] sel,
  output logic              load_hit
);

  logic [RD_MAX_W-1:0] rs_ext;

  assign rs_ext = RD_MAX_W'(rs);

  always_comb begin
    hit = '0;
    sel = FSEL_W'(FWD_RF);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit[i] = entries[i].valid & entries[i].we & (entries[i].rd != '0) &
               (entries[i].rd == rs_ext) & rs_used;
    end
    // walk oldest to youngest so the lowest matching index wins
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (hit[i-1]) sel = FSEL_W'(i);
    end
  end

  assign load_hit = hit[0] & entries[0].is_load;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: shift scoreboard of in-flight writers, stall/flush/issue decision,
// saturating perf counters. Define HAZARD_FWD_EN for operand forwarding with load-use-only stalls.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned FSEL_W = $clog2(DEPTH + 1)
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rf_we,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  output logic              stall,
  output logic              flush,
  output logic              issue,
  output logic [FSEL_W-1:0] fwd_rs1_sel,
  output logic [FSEL_W-1:0] fwd_rs2_sel,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  if (!depth_ok(DEPTH) || (REG_AW > RD_MAX_W)) begin : g_param_check
    $error("hazard_scoreboard: DEPTH or REG_AW out of supported range");
  end

  sb_entry_t          sb [DEPTH];
  sb_entry_t          next_entry;
  logic [DEPTH-1:0]   hit1, hit2;
  logic [FSEL_W-1:0]  sel1, sel2;
  logic               load_hit1, load_hit2;
  logic               stall_raw;
  logic [31:0]        stall_cnt_q, flush_cnt_q;

  hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .FSEL_W(FSEL_W)) u_match_rs1 (
    .rs       (id_rs1),
    .rs_used  (id_rs1_used),
    .entries  (sb),
    .hit      (hit1),
    .sel      (sel1),
    .load_hit (load_hit1)
  );

  hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .FSEL_W(FSEL_W)) u_match_rs2 (
    .rs       (id_rs2),
    .rs_used  (id_rs2_used),
    .entries  (sb),
    .hit      (hit2),
    .sel      (sel2),
    .load_hit (load_hit2)
  );

`ifdef HAZARD_FWD_EN
  logic unused_hits;
  assign unused_hits = ^{hit1, hit2};
  assign stall_raw   = load_hit1 | load_hit2;
  assign fwd_rs1_sel = stall ? FSEL_W'(FWD_RF) : sel1;
  assign fwd_rs2_sel = stall ? FSEL_W'(FWD_RF) : sel2;
`else
  logic unused_fwd;
  assign unused_fwd  = ^{sel1, sel2, load_hit1, load_hit2};
  assign stall_raw   = (|hit1) | (|hit2);
  assign fwd_rs1_sel = FSEL_W'(FWD_RF);
  assign fwd_rs2_sel = FSEL_W'(FWD_RF);
`endif

  // redirect overrides any stall: the ID instruction is squashed instead of held
  assign flush = ex_redirect;
  assign stall = id_valid & stall_raw & ~ex_redirect;
  assign issue = id_valid & ~stall_raw & ~ex_redirect;

  always_comb begin
    next_entry = '0;
    if (issue) begin
      next_entry.valid   = 1'b1;
      next_entry.rd      = RD_MAX_W'(id_rd);
      next_entry.we      = id_rf_we;
      next_entry.is_load = id_is_load;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) sb[i] <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb[0] <= next_entry;
      for (int unsigned i = 1; i < DEPTH; i++) sb[i] <= sb[i-1];
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised data/control-hazard unit for the in-order RISC-V pipeline, sitting beside the IF/ID and ID/EX registers. It tracks in-flight destination registers in a DEPTH-entry shift scoreboard and decides each cycle whether the ID-stage instruction issues, stalls, or is squashed. It optionally produces operand-forwarding selects and keeps saturating stall and flush performance counters.

## Interface
- REG_AW, 5: register-address width.
- DEPTH, 3: stages from EX to write-back inclusive, 2..6.
- FSEL_W, $clog2(DEPTH+1): forward-select width.
- cpu_clk  in  1  clock, rising edge.
- cpu_rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  source registers.
- id_rs1_used, id_rs2_used  in  1  source actually read.
- id_rd  in  REG_AW  destination register.
- id_rf_we  in  1  instruction writes RF.
- id_is_load  in  1  result available only at end of MEM.
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- flush  out  1  squash IF/ID and ID/EX contents.
- issue  out  1  ID instruction advances this cycle.
- fwd_rs1_sel, fwd_rs2_sel  out  FSEL_W  0 = RF, k = result of scoreboard entry k-1.
- stall_cnt, flush_cnt  out  32  saturating event counters.

## Operation
- Scoreboard entry i (0 = EX, DEPTH-1 = WB) holds {valid, rd, we, is_load}; all entries shift by one every cycle, oldest drops off.
- Entry 0 loads {id_valid & issue, id_rd, id_rf_we, id_is_load}; otherwise a bubble (valid = 0).
- Match on entry i: valid & we & rd != 0 & rd == rsN & rsN_used.
- Without forwarding: stall = id_valid & any match in any entry.
- With forwarding: stall = id_valid & match in entry 0 with is_load (load-use); every other match forwards, youngest (lowest i) wins, sel = i+1.
- x0 never matches; sel is 0 when no match or when stall is 1.
- ex_redirect has priority: flush = 1, stall = 0, issue = 0, entry 0 loads bubble.
- issue = id_valid & ~stall & ~ex_redirect.
- stall_cnt increments on cycles with stall = 1; flush_cnt on cycles with flush = 1; both hold at 32'hFFFF_FFFF.

## Timing
- stall, flush, issue, fwd_*_sel: combinational from inputs and scoreboard state, same cycle.
- Scoreboard and counters update on cpu_clk rising edge.
- Reset: all entries invalid; stall = 0, flush = 0, issue = 0 until id_valid, selects 0, counters 0. Reset mid-stall clears the stall on the next cycle.
- Back-to-back dependence, no forwarding: consumer stalls exactly DEPTH cycles.
- Load-use with forwarding: exactly 1 stall cycle, then sel = 2.
- Simultaneous redirect and stall condition: redirect wins, the stalled instruction is discarded.

## Configuration
- HAZARD_FWD_EN defined: forwarding logic and load-use-only stall as above; fwd_*_sel driven.
- Not defined: fwd_*_sel tied to 0; stall on any scoreboard match; is_load ignored.

## Structure
- hazard_pkg: scoreboard entry struct, FWD_RF = 0 constant, DEPTH bounds check.
- One sub-module hazard_match: compares one source against all entries, returns hit vector, youngest-hit index, and load-hit flag; instantiated twice (rs1, rs2).

## Test plan
- DEPTH=3, no FWD: addi x5 issued, next cycle add x6,x5,x1 -> stall = 1 for 3 cycles, then issue; stall_cnt = 3.
- FWD_EN: addi x5 then add x6,x5,x5 -> no stall, fwd_rs1_sel = fwd_rs2_sel = 1.
- FWD_EN: lw x7 then sub x8,x7,x2 -> stall 1 cycle, next cycle fwd_rs1_sel = 2, fwd_rs2_sel = 0.
- Writes to x0 followed by readers of x0 -> never stall, selects 0.
- ex_redirect during a load-use stall -> flush = 1, stall = 0, issue = 0; flush_cnt = 1; entry 0 bubble.
- Force stall_cnt to 32'hFFFF_FFFE, stall 3 cycles -> saturates at 32'hFFFF_FFFF; cpu_rst pulse -> counters 0, entries invalid.
